spi_seq: RTL and testbench
==========================

SPI_SEQ -- requirements
Module: spi_seq

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 4, meaning TX FIFO depth in bytes; legal values are 2, 4, 8 and 16.
REQ-002 SHALL have parameter RX_DEPTH, default 4, meaning RX FIFO depth in bytes when SPI_SEQ_RXFIFO_EN is defined; legal values are 2, 4, 8 and 16.
REQ-003 clock_in  input  1  single clock; all logic on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 tx_data  input  8  byte to transmit from the host side.
REQ-006 tx_valid  input  1  tx_data is valid this cycle.
REQ-007 tx_ready  output  1  TX FIFO not full.
REQ-008 rx_data  output  8  received byte, taken from the RX FIFO head.
REQ-009 rx_valid  output  1  RX FIFO not empty.
REQ-010 rx_ready  input  1  host consumes rx_data this cycle.
REQ-011 busy  output  1  a transfer is in progress, or the TX FIFO is non-empty.
REQ-012 overrun  output  1  sticky flag: a received byte was dropped.
REQ-013 spi_load  output  1  load strobe to the downstream shifter.
REQ-014 spi_datain  output  8  byte presented to the shifter.
REQ-015 spi_unload  output  1  capture strobe to the shifter's output latch.
REQ-016 spi_dataout  input  8  received byte from the shifter.

Function
REQ-017 TX FIFO: a push SHALL occur when tx_valid is high and tx_ready is high; there SHALL be no push when tx_valid is high and the FIFO is full.
REQ-018 The state machine SHALL have exactly the states IDLE, LOAD, SHIFT and UNLOAD.
REQ-019 IDLE -> LOAD SHALL occur on the edge where the TX FIFO is non-empty; in LOAD, spi_load=1 for exactly one cycle, spi_datain=FIFO head, and the head is popped on that edge.
REQ-020 LOAD -> SHIFT SHALL occur with a 3-bit counter cleared to 0; SHIFT SHALL last exactly 8 cycles (counter 0..7), with spi_load=0 and spi_unload=0.
REQ-021 SHIFT -> UNLOAD SHALL occur when the counter reaches 7; in UNLOAD, spi_unload=1 for exactly one cycle, and spi_dataout is written to the RX store on the edge that ends UNLOAD.
REQ-022 UNLOAD -> LOAD SHALL occur if the TX FIFO is non-empty at that edge, otherwise UNLOAD -> IDLE; back-to-back bytes therefore occupy exactly 10 cycles each.
REQ-023 spi_datain SHALL be 8'h00 in every state except LOAD.
REQ-024 The counter SHALL wrap modulo 8 and SHALL be used only in SHIFT.
REQ-025 A push on the same edge as the LOAD pop SHALL be accepted whenever the FIFO was not full before that edge, and FIFO occupancy SHALL remain correct.
REQ-026 A push into an empty FIFO SHALL make the FIFO non-empty on the next cycle; LOAD follows one cycle after that.
REQ-027 RX write while the RX store is full SHALL drop the byte and set overrun; overrun SHALL clear only on reset.
REQ-028 RX write and host pop on the same edge while the store is full SHALL both succeed, and overrun SHALL NOT be set.
REQ-029 busy SHALL be 1 in LOAD, SHIFT and UNLOAD, and SHALL also be 1 in IDLE whenever the TX FIFO is non-empty.

Reset
REQ-030 resetn low SHALL immediately force:
- state to IDLE and counter to 0;
- both FIFOs empty;
- spi_load=0, spi_unload=0, spi_datain=8'h00;
- rx_data=8'h00, rx_valid=0, overrun=0, tx_ready=1, busy=0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer and discard the in-flight byte, with no spi_unload pulse.
REQ-032 The first push SHALL be accepted on the first rising edge after resetn is released.

Configuration
REQ-033 The macro SPI_SEQ_RXFIFO_EN SHALL control the RX store.
REQ-034 With SPI_SEQ_RXFIFO_EN defined, the RX store SHALL be a RX_DEPTH-entry FIFO.
REQ-035 Without SPI_SEQ_RXFIFO_EN, the RX store SHALL be a single holding register with a valid bit, and RX_DEPTH SHALL be ignored.
REQ-036 Without SPI_SEQ_RXFIFO_EN, a write into the holding register while it is valid and not being popped SHALL set overrun and keep the old byte.

Verification
REQ-037 Reset, then push 8'hA5 -> spi_load is high for 1 cycle with spi_datain=8'hA5, then 8 SHIFT cycles, then spi_unload high for 1 cycle.
REQ-038 Push 8'h11, 8'h22, 8'h33 back-to-back -> spi_load pulses exactly 10 cycles apart, and busy stays high until the final UNLOAD exits.
REQ-039 Model spi_dataout=8'h3C at UNLOAD with rx_ready=1 -> rx_valid=1 and rx_data=8'h3C on the next cycle, and overrun stays 0.
REQ-040 Hold rx_ready=0, then send RX_DEPTH+1 bytes (1 byte without the macro) -> overrun=1, and the first bytes are returned in order.
REQ-041 Fill the TX FIFO to TX_DEPTH -> tx_ready=0; an extra push of 8'hFF is not stored and is never seen on spi_datain.
REQ-042 Pulse resetn low during SHIFT cycle 4 -> all outputs take their reset values, no spi_unload pulse occurs, and a new push afterwards transfers normally.

Source files
------------

// File: rtl/spi_seq.sv
// Byte sequencer: TX FIFO -> LOAD/SHIFT/UNLOAD handshake with a parallel SPI shifter -> RX store.
// Define SPI_SEQ_RXFIFO_EN for an RX_DEPTH-entry RX FIFO; otherwise a single holding register.
module spi_seq #(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic       clock_in,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       overrun,
    output logic       spi_load,
    output logic [7:0] spi_datain,
    output logic       spi_unload,
    input  logic [7:0] spi_dataout
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int TCW = $clog2(TX_DEPTH + 1);

    if (TX_DEPTH < 2 || TX_DEPTH > 16 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_tx_depth
        $error("spi_seq: TX_DEPTH must be 2, 4, 8 or 16");
    end
    if (RX_DEPTH < 2 || RX_DEPTH > 16 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_rx_depth
        $error("spi_seq: RX_DEPTH must be 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, UNLOAD} state_e;

    state_e         state_q;
    logic [2:0]     bit_cnt_q;
    logic           spi_load_q;
    logic           spi_unload_q;
    logic [7:0]     spi_datain_q;
    logic           overrun_q;

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wr_q, tx_rd_q;
    logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
    logic           tx_push, tx_pop, tx_nonempty;
    logic           rx_wr, rx_pop, rx_accept;

    assign tx_nonempty = (tx_cnt_q != '0);
    assign tx_ready    = (tx_cnt_q != TCW'(TX_DEPTH));
    assign tx_push     = tx_valid & tx_ready;
    // The head is popped on the same edge that enters LOAD, from IDLE or straight out of UNLOAD.
    assign tx_pop      = tx_nonempty & ((state_q == IDLE) | (state_q == UNLOAD));
    assign rx_wr       = (state_q == UNLOAD);
    assign rx_pop      = rx_valid & rx_ready;
    assign busy        = (state_q != IDLE) | tx_nonempty;

    assign spi_load    = spi_load_q;
    assign spi_unload  = spi_unload_q;
    assign spi_datain  = spi_datain_q;
    assign overrun     = overrun_q;

    always_comb begin
        // NOTE: default first so every path assigns tx_cnt_d and no latch is inferred.
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + TCW'(1);
        else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - TCW'(1);
    end

    // NOTE: storage arrays carry no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clock_in) begin
        if (tx_push) tx_mem[tx_wr_q] <= tx_data;
    end

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            if (tx_push) tx_wr_q <= tx_wr_q + TAW'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + TAW'(1);
            tx_cnt_q <= tx_cnt_d;
        end
    end

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            spi_load_q   <= 1'b0;
            spi_unload_q <= 1'b0;
            spi_datain_q <= 8'h00;
        end else begin
            spi_load_q   <= 1'b0;
            spi_unload_q <= 1'b0;
            spi_datain_q <= 8'h00;
            case (state_q)
                IDLE, UNLOAD: begin
                    if (tx_nonempty) begin
                        state_q      <= LOAD;
                        spi_load_q   <= 1'b1;
                        spi_datain_q <= tx_mem[tx_rd_q];
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LOAD: begin
                    state_q   <= SHIFT;
                    bit_cnt_q <= '0;
                end
                SHIFT: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_q      <= UNLOAD;
                        spi_unload_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SPI_SEQ_RXFIFO_EN
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int RCW = $clog2(RX_DEPTH + 1);

    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wr_q, rx_rd_q;
    logic [RCW-1:0] rx_cnt_q, rx_cnt_d;

    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign rx_accept = rx_wr & ((rx_cnt_q != RCW'(RX_DEPTH)) | rx_pop);
    assign rx_valid  = (rx_cnt_q != '0);
    assign rx_data   = rx_valid ? rx_mem[rx_rd_q] : 8'h00;

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        if (rx_accept && !rx_pop) rx_cnt_d = rx_cnt_q + RCW'(1);
        else if (!rx_accept && rx_pop) rx_cnt_d = rx_cnt_q - RCW'(1);
    end

    always_ff @(posedge clock_in) begin
        if (rx_accept) rx_mem[rx_wr_q] <= spi_dataout;
    end

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
            rx_cnt_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (rx_accept) rx_wr_q <= rx_wr_q + RAW'(1);
            if (rx_pop)    rx_rd_q <= rx_rd_q + RAW'(1);
            rx_cnt_q <= rx_cnt_d;
            if (rx_wr && !rx_accept) overrun_q <= 1'b1;
        end
    end
`else
    logic [7:0] rx_hold_q;
    logic       rx_hold_vld_q;

    assign rx_accept = rx_wr & (~rx_hold_vld_q | rx_pop);
    assign rx_valid  = rx_hold_vld_q;
    assign rx_data   = rx_hold_q;

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            rx_hold_q     <= 8'h00;
            rx_hold_vld_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            if (rx_accept) begin
                rx_hold_q     <= spi_dataout;
                rx_hold_vld_q <= 1'b1;
            end else if (rx_pop) begin
                rx_hold_vld_q <= 1'b0;
            end
            if (rx_wr && !rx_accept) overrun_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_seq.sv
// Scoreboard bench for spi_seq: a transfer-timeline reference model predicts loads, unloads,
// flags and RX contents; monitors compare the DUT against it every cycle.
module tb_spi_seq;
    localparam int TX_DEPTH = 4;
    localparam int RX_DEPTH = 4;
`ifdef SPI_SEQ_RXFIFO_EN
    localparam int RX_CAP = RX_DEPTH;
`else
    localparam int RX_CAP = 1;
`endif

    logic       clock_in = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       busy;
    logic       overrun;
    logic       spi_load;
    logic [7:0] spi_datain;
    logic       spi_unload;
    logic [7:0] spi_dataout = 8'h00;

    spi_seq #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clock_in(clock_in), .resetn(resetn),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .overrun(overrun),
        .spi_load(spi_load), .spi_datain(spi_datain), .spi_unload(spi_unload),
        .spi_dataout(spi_dataout)
    );

    initial forever #5 clock_in = ~clock_in;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each transfer starts at an edge where the sequencer is free and bytes
    // are queued, then owns the next 10 edges (unload visible after +9, RX write at +10).
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] sb_tx[$];
    int  e, free_e, unload_e, write_e;
    bit  exp_load, exp_unload, exp_busy, exp_tx_ready, exp_ovr;

    task automatic model_reset();
        txq.delete(); rxq.delete(); sb_tx.delete();
        e = 0; free_e = 0; unload_e = -1; write_e = -1;
        exp_load = 0; exp_unload = 0; exp_busy = 0; exp_tx_ready = 1; exp_ovr = 0;
    endtask

    task automatic model_step();
        int pre;
        bit load;
        if (rxq.size() > 0 && rx_ready) void'(rxq.pop_front());
        if (e == write_e) begin
            if (rxq.size() < RX_CAP) rxq.push_back(spi_dataout);
            else exp_ovr = 1;
        end
        pre  = txq.size();
        load = (e >= free_e) && (pre > 0);
        if (load) begin
            sb_tx.push_back(txq.pop_front());
            free_e = e + 10; unload_e = e + 9; write_e = e + 10;
        end
        if (tx_valid && pre < TX_DEPTH) txq.push_back(tx_data);
        exp_load     = load;
        exp_unload   = (e == unload_e);
        exp_busy     = (e < write_e) || (txq.size() > 0);
        exp_tx_ready = (txq.size() < TX_DEPTH);
        e++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock_in or negedge resetn);
            if (!resetn) model_reset();
            else model_step();
        end
    end

    // Monitor: samples outputs mid-low-phase, pops the TX scoreboard whenever spi_load shows.
    time load_t[$];
    int  n_unload = 0;
    bit  saw_ff = 0;

    initial forever begin
        @(negedge clock_in); #2;
        if (!resetn) begin
            check("rst_spi_load", spi_load, 0);
            check("rst_spi_unload", spi_unload, 0);
            check("rst_spi_datain", spi_datain, 8'h00);
            check("rst_rx_data", rx_data, 8'h00);
            check("rst_rx_valid", rx_valid, 0);
            check("rst_overrun", overrun, 0);
            check("rst_tx_ready", tx_ready, 1);
            check("rst_busy", busy, 0);
        end else begin
            check("spi_load", spi_load, exp_load);
            check("spi_unload", spi_unload, exp_unload);
            check("busy", busy, exp_busy);
            check("tx_ready", tx_ready, exp_tx_ready);
            check("overrun", overrun, exp_ovr);
            check("rx_valid", rx_valid, rxq.size() > 0);
            if (rxq.size() > 0) check("rx_data", rx_data, rxq[0]);
            if (spi_load === 1'b1) begin
                load_t.push_back($time);
                if (spi_datain == 8'hFF) saw_ff = 1;
                if (sb_tx.size() == 0) check("spi_load_unexpected", spi_load, 0);
                else check("spi_datain", spi_datain, sb_tx.pop_front());
            end else begin
                check("spi_datain_idle", spi_datain, 8'h00);
            end
            if (spi_unload === 1'b1) n_unload++;
        end
    end

    // Shifter stand-in: returns an arbitrary byte unless a fixed one is requested.
    bit         dout_fixed = 0;
    logic [7:0] dout_val = 8'h00;
    initial forever begin
        @(negedge clock_in);
        spi_dataout = dout_fixed ? dout_val : 8'($urandom);
    end

    task automatic push(input logic [7:0] b);
        int n = 0;
        @(negedge clock_in);
        tx_valid = 1'b1;
        tx_data  = b;
        while (!exp_tx_ready && n < 200) begin
            @(negedge clock_in);
            n++;
        end
        check("push_ready", tx_ready, 1);
    endtask

    task automatic idle();
        @(negedge clock_in);
        tx_valid = 1'b0;
    endtask

    task automatic wait_load(input int budget);
        int n = 0;
        do begin @(negedge clock_in); #3; n++; end while (spi_load !== 1'b1 && n < budget);
        check("wait_load", spi_load, 1);
    endtask

    task automatic wait_unload(input int budget);
        int n = 0;
        do begin @(negedge clock_in); #3; n++; end while (spi_unload !== 1'b1 && n < budget);
        check("wait_unload", spi_unload, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin @(negedge clock_in); #3; n++; end while (busy !== 1'b0 && n < budget);
        check("wait_idle", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int snap;
        repeat (3) @(negedge clock_in);

        // First push lands on the first edge after reset release; single-byte frame shape.
        resetn   = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        @(negedge clock_in);
        tx_valid = 1'b0;
        #3 check("first_push_busy", busy, 1);
        wait_load(20);
        check("a5_datain", spi_datain, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock_in); #3;
            check("a5_shift_load", spi_load, 0);
            check("a5_shift_unload", spi_unload, 0);
        end
        @(negedge clock_in); #3;
        check("a5_unload", spi_unload, 1);
        @(negedge clock_in); #3;
        check("a5_unload_one_cycle", spi_unload, 0);

        // Known received byte reaches rx_data the cycle after UNLOAD.
        dout_fixed = 1; dout_val = 8'h3C; rx_ready = 1'b1;
        push(8'h5A); idle();
        wait_unload(40);
        @(negedge clock_in); #3;
        check("rx_3c_valid", rx_valid, 1);
        check("rx_3c_data", rx_data, 8'h3C);
        check("rx_3c_overrun", overrun, 0);
        dout_fixed = 0;
        wait_idle(40);

        // Back-to-back bytes load exactly 10 cycles apart.
        load_t.delete();
        push(8'h11); push(8'h22); push(8'h33); idle();
        wait_idle(60);
        check("b2b_load_count", load_t.size(), 3);
        if (load_t.size() == 3) begin
            check("b2b_gap1", 32'(load_t[1] - load_t[0]), 100);
            check("b2b_gap2", 32'(load_t[2] - load_t[1]), 100);
        end

        // Fill the TX FIFO; an extra 8'hFF while full must be dropped.
        saw_ff = 0;
        k = 0;
        @(negedge clock_in);
        while (exp_tx_ready && k < 40) begin
            tx_valid = 1'b1;
            tx_data  = 8'(k + 1);
            k++;
            @(negedge clock_in);
        end
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        #3 check("tx_full_ready", tx_ready, 0);
        idle();
        wait_idle(200);
        check("ff_never_loaded", saw_ff, 0);

        // Overflow the RX store with the host stalled, then drain in order.
        rx_ready = 1'b0;
        for (int i = 0; i <= RX_CAP; i++) push(8'h40 + 8'(i));
        idle();
        wait_idle(300);
        check("overrun_set", overrun, 1);
        rx_ready = 1'b1;
        repeat (RX_CAP + 2) @(negedge clock_in);
        #3 check("rx_drained", rx_valid, 0);
        check("overrun_sticky", overrun, 1);

        // Reset in SHIFT cycle 4 aborts the frame without an unload pulse.
        push(8'h77); idle();
        wait_load(20);
        repeat (5) @(negedge clock_in);
        resetn = 1'b0;
        #3;
        check("midrst_spi_load", spi_load, 0);
        check("midrst_spi_unload", spi_unload, 0);
        check("midrst_spi_datain", spi_datain, 8'h00);
        check("midrst_busy", busy, 0);
        check("midrst_tx_ready", tx_ready, 1);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_overrun", overrun, 0);
        snap = n_unload;
        repeat (2) @(negedge clock_in);
        resetn = 1'b1;
        repeat (15) @(negedge clock_in);
        #3 check("midrst_no_unload", n_unload - snap, 0);
        push(8'h99); idle();
        wait_unload(40);
        wait_idle(40);

        // Randomized traffic with one reset pulse in the middle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock_in);
            resetn   = (i != 1500);
            tx_valid = ($urandom_range(0, 2) == 0);
            tx_data  = 8'($urandom);
            rx_ready = ($urandom_range(0, 1) == 1);
        end
        @(negedge clock_in);
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        wait_idle(400);
        repeat (RX_CAP + 2) @(negedge clock_in);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
